// File: rtl/p256_squarer.sv
`timescale 1ns/1ps
// p256_squarer: multi-cycle 256x256 product-scanning squarer, one 32x32 multiply per cycle.
// Optional macro P256_SQR_SYMMETRY_EN: compute each cross product once and add it doubled.
//
// state   | meaning
// IDLE    | waiting for start, outputs zero
// MAC     | accumulate a[i]*a[k-i] for the current column k
// COL_END | retire limb r[k] from the accumulator, advance to column k+1
// FINISH  | retire final limb r[15]
// DONE    | result valid on a_high/a_low, start restarts
module p256_squarer #(
  parameter int LIMB_W    = 32,
  parameter int NUM_LIMBS = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [LIMB_W*NUM_LIMBS-1:0]   a_in,
  output logic                          busy,
  output logic                          done,
  output logic [LIMB_W*NUM_LIMBS-1:0]   a_high,
  output logic [LIMB_W*NUM_LIMBS-1:0]   a_low
);

  localparam int OP_W  = LIMB_W * NUM_LIMBS;
  localparam int ACC_W = 96;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_COL_END,
    S_FINISH,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     a_q, a_d;
  logic [2*OP_W-1:0]   r_q, r_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [3:0]          k_q, k_d;
  logic [2:0]          i_q, i_d;

  logic [2:0]          j;
  logic [2:0]          i_last;
  logic [3:0]          k_nx;
  logic [2*LIMB_W-1:0] op_i, op_j, prod;
  logic [ACC_W-1:0]    addend;

  always_comb begin
    j    = k_q[2:0] - i_q;
    k_nx = k_q + 4'd1;
    op_i = {{LIMB_W{1'b0}}, a_q[i_q*LIMB_W +: LIMB_W]};
    op_j = {{LIMB_W{1'b0}}, a_q[j*LIMB_W +: LIMB_W]};
    prod = op_i * op_j;
`ifdef P256_SQR_SYMMETRY_EN
    // Only i <= k-i is visited, so every off-diagonal pair stands in for its mirror.
    i_last = k_q[3:1];
    if (i_q != j)
      addend = {{(ACC_W-2*LIMB_W-1){1'b0}}, prod, 1'b0};
    else
      addend = {{(ACC_W-2*LIMB_W){1'b0}}, prod};
`else
    i_last = (k_q > 4'd7) ? 3'd7 : k_q[2:0];
    addend = {{(ACC_W-2*LIMB_W){1'b0}}, prod};
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    r_d     = r_q;
    acc_d   = acc_q;
    k_d     = k_q;
    i_d     = i_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a_in;
          r_d     = '0;
          acc_d   = '0;
          k_d     = 4'd0;
          i_d     = 3'd0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + addend;
        if (i_q == i_last) state_d = S_COL_END;
        else               i_d     = i_q + 3'd1;
      end
      S_COL_END: begin
        r_d[k_q*LIMB_W +: LIMB_W] = acc_q[LIMB_W-1:0];
        acc_d = acc_q >> LIMB_W;
        if (k_q == 4'd14) begin
          state_d = S_FINISH;
        end else begin
          k_d     = k_nx;
          // first row of column k+1 is max(0, k+1-7)
          i_d     = k_nx[3] ? (k_nx[2:0] + 3'd1) : 3'd0;
          state_d = S_MAC;
        end
      end
      S_FINISH: begin
        r_d[15*LIMB_W +: LIMB_W] = acc_q[LIMB_W-1:0];
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      r_q     <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      r_q     <= r_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      i_q     <= i_d;
    end
  end

  // Result limbs are only exposed in DONE, so partial columns never reach the reducer.
  assign busy   = (state_q == S_MAC) || (state_q == S_COL_END) || (state_q == S_FINISH);
  assign done   = (state_q == S_DONE);
  assign a_low  = done ? r_q[OP_W-1:0]      : '0;
  assign a_high = done ? r_q[2*OP_W-1:OP_W] : '0;

endmodule

// File: tb/tb_p256_squarer.sv
`timescale 1ns/1ps
// tb_p256_squarer: directed self-checking bench for the 256-bit squarer.
module tb_p256_squarer;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [255:0] a_in;
  logic         busy;
  logic         done;
  logic [255:0] a_high;
  logic [255:0] a_low;

  int passed = 0;
  int total  = 0;

`ifdef P256_SQR_SYMMETRY_EN
  localparam int LAT_BUSY = 52;
  localparam int LAT_DONE = 53;
`else
  localparam int LAT_BUSY = 80;
  localparam int LAT_DONE = 81;
`endif

  p256_squarer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a_in   (a_in),
    .busy   (busy),
    .done   (done),
    .a_high (a_high),
    .a_low  (a_low)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Start one op, scramble a_in after acceptance, count busy cycles and the done cycle.
  task automatic run_op(input logic [255:0] a, output int busy_cnt, output int done_cyc);
    int cyc;
    @(negedge clk);
    a_in  = a;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    a_in     = ~a;
    cyc      = 1;
    busy_cnt = 0;
    done_cyc = -1;
    while (cyc < 200) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (a_high !== 256'd0) $display("FAIL reset_a_high got %h want 0", a_high); else passed++;
    total++; if (a_low !== 256'd0) $display("FAIL reset_a_low got %h want 0", a_low); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    int bc, dc;
    run_op(256'd0, bc, dc);
    total++; if (bc !== LAT_BUSY) $display("FAIL zero_busy_cycles got %0d want %0d", bc, LAT_BUSY); else passed++;
    total++; if (dc !== LAT_DONE) $display("FAIL zero_done_cycle got %0d want %0d", dc, LAT_DONE); else passed++;
    total++; if (a_high !== 256'd0) $display("FAIL zero_a_high got %h want 0", a_high); else passed++;
    total++; if (a_low !== 256'd0) $display("FAIL zero_a_low got %h want 0", a_low); else passed++;
  endtask

  task automatic test_vector(input string name, input logic [255:0] a,
                             input logic [255:0] exp_hi, input logic [255:0] exp_lo);
    int bc, dc;
    run_op(a, bc, dc);
    total++; if (dc !== LAT_DONE) $display("FAIL %s_done_cycle got %0d want %0d", name, dc, LAT_DONE); else passed++;
    total++; if (a_high !== exp_hi) $display("FAIL %s_a_high got %h want %h", name, a_high, exp_hi); else passed++;
    total++; if (a_low !== exp_lo) $display("FAIL %s_a_low got %h want %h", name, a_low, exp_lo); else passed++;
  endtask

  task automatic test_vectors();
    logic [255:0] one;
    one = 256'd1;
    test_vector("one",      one,                    256'd0,       one);
    test_vector("all_ones", ~256'd0,                ~one,         one);
    test_vector("pow128",   one << 128,             one,          256'd0);
    test_vector("limb_ff",  256'hFFFF_FFFF,         256'd0,       256'h0000_0000_FFFF_FFFE_0000_0001);
    test_vector("pow255",   one << 255,             one << 254,   256'd0);
    test_vector("limbs0_1", (one << 32) | one,      256'd0,       256'h1_0000_0002_0000_0001);
    test_vector("limbs0_7", (one << 224) | one,     one << 192,   (one << 225) | one);
  endtask

  task automatic test_mid_start();
    int cyc, dc;
    @(negedge clk);
    a_in  = 256'hFFFF_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = 256'd1;
    cyc   = 1;
    dc    = -1;
    while (cyc < 200) begin
      if (done) begin
        dc = cyc;
        break;
      end
      start = (cyc == 10);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    total++; if (dc !== LAT_DONE) $display("FAIL midstart_done_cycle got %0d want %0d", dc, LAT_DONE); else passed++;
    total++; if (a_low !== 256'h0000_0000_FFFF_FFFE_0000_0001) $display("FAIL midstart_a_low got %h want fffffffe00000001", a_low); else passed++;
    total++; if (a_high !== 256'd0) $display("FAIL midstart_a_high got %h want 0", a_high); else passed++;
  endtask

  task automatic test_restart();
    int cyc, dc;
    logic [255:0] one;
    one = 256'd1;
    repeat (5) @(negedge clk);
    total++; if (done !== 1'b1) $display("FAIL hold_done got %b want 1", done); else passed++;
    total++; if (a_low !== 256'h0000_0000_FFFF_FFFE_0000_0001) $display("FAIL hold_a_low got %h want fffffffe00000001", a_low); else passed++;
    a_in  = (one << 96) | (one << 64);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_in  = '0;
    total++; if (done !== 1'b0) $display("FAIL restart_done_drop got %b want 0", done); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL restart_busy got %b want 1", busy); else passed++;
    total++; if (a_low !== 256'd0) $display("FAIL restart_a_low_clear got %h want 0", a_low); else passed++;
    cyc = 1;
    dc  = -1;
    while (cyc < 200) begin
      if (done) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    // (2^96 + 2^64)^2 = 2^192 + 2^161 + 2^128
    total++; if (dc !== LAT_DONE) $display("FAIL restart_done_cycle got %0d want %0d", dc, LAT_DONE); else passed++;
    total++; if (a_low !== ((one << 192) | (one << 161) | (one << 128))) $display("FAIL restart_a_low got %h", a_low); else passed++;
    total++; if (a_high !== 256'd0) $display("FAIL restart_a_high got %h want 0", a_high); else passed++;
  endtask

  task automatic test_reset_abort();
    int bc, dc;
    @(negedge clk);
    a_in  = ~256'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL abort_done got %b want 0", done); else passed++;
    total++; if (a_high !== 256'd0) $display("FAIL abort_a_high got %h want 0", a_high); else passed++;
    total++; if (a_low !== 256'd0) $display("FAIL abort_a_low got %h want 0", a_low); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(256'h1234, bc, dc);
    total++; if (bc !== LAT_BUSY) $display("FAIL abort_new_busy_cycles got %0d want %0d", bc, LAT_BUSY); else passed++;
    total++; if (dc !== LAT_DONE) $display("FAIL abort_new_done_cycle got %0d want %0d", dc, LAT_DONE); else passed++;
    total++; if (a_low !== 256'h14B_5A90) $display("FAIL abort_new_a_low got %h want 14b5a90", a_low); else passed++;
    total++; if (a_high !== 256'd0) $display("FAIL abort_new_a_high got %h want 0", a_high); else passed++;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_vectors();
    test_mid_start();
    test_restart();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
